// File: rtl/pipelined_multiplier.sv
// Unsigned DATA_LEN x DATA_LEN multiplier returning the low DATA_LEN bits of the product,
// delayed by PIPELINE_STAGE-1 register stages behind a combinational product stage.
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
);

    // Context width is DATA_LEN, so the upper half of the product is never formed.
    logic [DATA_LEN-1:0] w_product;
    assign w_product = a * b;

    generate
        if (PIPELINE_STAGE <= 1) begin : g_comb
            // Depth 1 has no state: clock and reset are intentionally unused.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ reset;
            assign result           = w_product;
        end else begin : g_pipe
            localparam int NREG = PIPELINE_STAGE - 1;

            logic [NREG-1:0][DATA_LEN-1:0] r_stage;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_stage <= '0;
                end else begin
                    r_stage[0] <= w_product;
                    for (int i = 1; i < NREG; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign result = r_stage[NREG-1];
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench: directed cases on the default configuration plus a randomized
// sweep of depths 1/3/4 at widths 8 and 32 against a transaction-log reference model.
module tb_pipelined_multiplier;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a     = 32'h0;
    logic [31:0] b     = 32'h0;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    // Instance table: index -> (width, latency = PIPELINE_STAGE-1)
    int cfg_w [7] = '{32, 8, 8, 8, 32, 32, 32};
    int cfg_d [7] = '{ 1, 0, 2, 3,  0,  2,  3};

    logic [31:0] r_main, r32_1, r32_3, r32_4;
    logic [7:0]  r8_1, r8_3, r8_4;
    logic [31:0] res [7];

    assign res[0] = r_main;
    assign res[1] = {24'h0, r8_1};
    assign res[2] = {24'h0, r8_3};
    assign res[3] = {24'h0, r8_4};
    assign res[4] = r32_1;
    assign res[5] = r32_3;
    assign res[6] = r32_4;

    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) u_main (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r_main));
    pipelined_multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(1)) u_8_1 (
        .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .result(r8_1));
    pipelined_multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(3)) u_8_3 (
        .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .result(r8_3));
    pipelined_multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(4)) u_8_4 (
        .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .result(r8_4));
    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) u_32_1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r32_1));
    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(3)) u_32_3 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r32_3));
    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) u_32_4 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r32_4));

    // Reference model: a log of operands sampled at every rising edge, with a flag that
    // is false for edges taken in reset or whose data was lost to a later reset.
    logic [31:0] log_a  [$];
    logic [31:0] log_b  [$];
    bit          log_ok [$];

    always @(posedge clk) begin
        log_a.push_back(a);
        log_b.push_back(b);
        log_ok.push_back(reset === 1'b1);
    end

    always @(negedge reset) begin
        foreach (log_ok[i]) log_ok[i] = 1'b0;
    end

    function automatic logic [31:0] model(input int w, input int d);
        logic [63:0] p;
        int          j;
        if (d == 0) begin
            p = 64'(a) * 64'(b);
        end else begin
            if (reset !== 1'b1) return 32'h0;
            j = log_a.size() - d;
            if (j < 0) return 32'h0;
            if (!log_ok[j]) return 32'h0;
            p = 64'(log_a[j]) * 64'(log_b[j]);
        end
        if (w < 32) p = p & ((64'd1 << w) - 64'd1);
        return p[31:0];
    endfunction

    // Present operands at a falling edge and return at the next falling edge.
    task automatic tick(input logic [31:0] na, input logic [31:0] nb);
        a = na;
        b = nb;
        @(negedge clk);
    endtask

    task automatic test_reset();
        a = $urandom;
        b = $urandom;
        repeat (2) @(negedge clk);
        $display("[TB] reset held a=%h b=%h result=%h", a, b, res[0]);
        for (int i = 0; i < 7; i++) begin
            logic [31:0] exp_v;
            exp_v = (cfg_d[i] == 0) ? model(cfg_w[i], 0) : 32'h0;
            tests_run++;
            if (res[i] !== exp_v) begin
                fails++;
                $display("FAIL reset_state inst%0d: result=%h expected=%h", i, res[i], exp_v);
            end
        end
        a     = 32'h0;
        b     = 32'h0;
        reset = 1'b1;
        tick(32'h0, 32'h0);
        tests_run++;
        if (res[0] !== 32'h0) begin
            fails++;
            $display("FAIL reset_release: result=%h expected=00000000", res[0]);
        end
    endtask

    task automatic test_basic();
        tick(32'd3, 32'd5);
        $display("[TB] basic a=3 b=5 result=%0d", res[0]);
        tests_run++;
        if (res[0] !== 32'd15) begin
            fails++;
            $display("FAIL basic_product: result=%0d expected=15", res[0]);
        end
        tick(32'd0, 32'd0);
        $display("[TB] basic a=0 b=0 result=%0d", res[0]);
        tests_run++;
        if (res[0] !== 32'd0) begin
            fails++;
            $display("FAIL basic_flush: result=%0d expected=0", res[0]);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] ta [3] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [3] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [31:0] te [3] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE};
        for (int i = 0; i < 3; i++) begin
            tick(ta[i], tb[i]);
            $display("[TB] trunc a=%h b=%h result=%h", ta[i], tb[i], res[0]);
            tests_run++;
            if (res[0] !== te[i]) begin
                fails++;
                $display("FAIL truncation%0d: result=%h expected=%h", i, res[0], te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [4] = '{32'd2, 32'd10, 32'd0,   32'd65535};
        logic [31:0] bb [4] = '{32'd7, 32'd10, 32'd123, 32'd65537};
        logic [31:0] be [4] = '{32'd14, 32'd100, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            tick(ba[i], bb[i]);
            $display("[TB] stream a=%0d b=%0d result=%h", ba[i], bb[i], res[0]);
            tests_run++;
            if (res[0] !== be[i]) begin
                fails++;
                $display("FAIL back_to_back%0d: result=%h expected=%h", i, res[0], be[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        a = 32'd6;
        b = 32'd7;
        @(posedge clk);
        #2;
        tests_run++;
        if (res[0] !== 32'd42) begin
            fails++;
            $display("FAIL mid_pre_reset: result=%0d expected=42", res[0]);
        end
        reset = 1'b0;
        #1;
        $display("[TB] mid reset asserted result=%0d p3=%0d p4=%0d", res[0], res[5], res[6]);
        tests_run++;
        if (res[0] !== 32'd0 || res[5] !== 32'd0 || res[6] !== 32'd0) begin
            fails++;
            $display("FAIL mid_async_clear: p2=%0d p3=%0d p4=%0d expected all 0", res[0], res[5], res[6]);
        end
        a = 32'd0;
        b = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(32'd0, 32'd0);
            tests_run++;
            if (res[0] !== 32'd0 || res[5] !== 32'd0 || res[6] !== 32'd0) begin
                fails++;
                $display("FAIL mid_flush%0d: p2=%0d p3=%0d p4=%0d expected all 0", i, res[0], res[5], res[6]);
            end
        end
        tick(32'd6, 32'd7);
        $display("[TB] mid reapply a=6 b=7 result=%0d", res[0]);
        tests_run++;
        if (res[0] !== 32'd42) begin
            fails++;
            $display("FAIL mid_reapply_p2: result=%0d expected=42", res[0]);
        end
        tick(32'd0, 32'd0);
        tests_run++;
        if (res[5] !== 32'd42) begin
            fails++;
            $display("FAIL mid_reapply_p3: result=%0d expected=42", res[5]);
        end
        tick(32'd0, 32'd0);
        tests_run++;
        if (res[6] !== 32'd42) begin
            fails++;
            $display("FAIL mid_reapply_p4: result=%0d expected=42", res[6]);
        end
    endtask

    task automatic test_sweep();
        for (int n = 0; n < 200; n++) begin
            int          sel;
            logic [31:0] exp_v;
            sel = $urandom_range(0, 7);
            a   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            #1;
            for (int i = 0; i < 7; i++) begin
                if (cfg_d[i] == 0) begin
                    exp_v = model(cfg_w[i], 0);
                    tests_run++;
                    if (res[i] !== exp_v) begin
                        fails++;
                        $display("FAIL sweep_comb inst%0d cyc%0d: result=%h expected=%h", i, n, res[i], exp_v);
                    end
                end
            end
            @(negedge clk);
            $display("[TB] sweep cyc%0d a=%h b=%h p2=%h p3=%h p4=%h", n, a, b, res[0], res[5], res[6]);
            for (int i = 0; i < 7; i++) begin
                exp_v = model(cfg_w[i], cfg_d[i]);
                tests_run++;
                if (res[i] !== exp_v) begin
                    fails++;
                    $display("FAIL sweep inst%0d W=%0d lat=%0d cyc%0d: result=%h expected=%h",
                             i, cfg_w[i], cfg_d[i], n, res[i], exp_v);
                end
            end
            if (n == 100) begin
                #2;
                reset = 1'b0;
                #1;
                for (int i = 0; i < 7; i++) begin
                    exp_v = model(cfg_w[i], cfg_d[i]);
                    tests_run++;
                    if (res[i] !== exp_v) begin
                        fails++;
                        $display("FAIL sweep_reset inst%0d: result=%h expected=%h", i, res[i], exp_v);
                    end
                end
                @(negedge clk);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
